// File: rtl/int_queue_reader_pkg.sv
// Shared DMA interrupt-queue definitions: entry field offsets, reader FSM encoding and
// the FIFO entry width derivation.
package int_queue_reader_pkg;

    localparam int unsigned OPDONE_BIT  = 0;
    localparam int unsigned RDERR_BIT   = 1;
    localparam int unsigned WRERR_BIT   = 2;
    localparam int unsigned INVDESC_BIT = 3;
    localparam int unsigned DESCNUM_LSB = 4;
    localparam int unsigned NUM_FLAGS   = 4;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_WAIT = 2'd1;
    localparam logic [1:0] STATE_HOLD = 2'd2;

    typedef enum logic [1:0] {
        StIdle = STATE_IDLE,
        StWait = STATE_WAIT,
        StHold = STATE_HOLD
    } readState_e;

    function automatic int unsigned fifoWidth(input int unsigned descNumWidth);
        return descNumWidth + NUM_FLAGS;
    endfunction

endpackage

// File: rtl/int_queue_reader_if.sv
// Read port of the DMA interrupt event FIFO, including its ECC status flags.
interface int_queue_reader_if
    import int_queue_reader_pkg::*;
#(
    parameter int unsigned DESC_NUM_WIDTH = 5
);
    localparam int unsigned FIFO_WIDTH = fifoWidth(DESC_NUM_WIDTH);

    logic                  fifoEmpty;
    logic                  rdEn;
    logic [FIFO_WIDTH-1:0] rdData;
    logic                  fifoSbErr;
    logic                  fifoDbErr;

    modport master (
        output rdEn,
        input  fifoEmpty,
        input  rdData,
        input  fifoSbErr,
        input  fifoDbErr
    );

    modport slave (
        input  rdEn,
        output fifoEmpty,
        output rdData,
        output fifoSbErr,
        output fifoDbErr
    );

endinterface

// File: rtl/int_queue_reader.sv
// Pops DMA interrupt events one at a time, holds the current one in a status register and
// raises a level irq until software clears it; also keeps sticky FIFO ECC flags.
module int_queue_reader
    import int_queue_reader_pkg::*;
#(
    parameter int unsigned DESC_NUM_WIDTH = 5,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    int_queue_reader_if.master        fifo,
    input  logic [NUM_FLAGS-1:0]      intMask,
    input  logic                      clrEn,
    input  logic                      eccClr,
    output logic                      irq,
    output logic                      stsValid,
    output logic [DESC_NUM_WIDTH-1:0] stsDescNum,
    output logic [NUM_FLAGS-1:0]      stsFlags,
    output logic                      eccSbSticky,
    output logic                      eccDbSticky,
    output logic [7:0]                discardCnt
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : gBadLatency
        $error("int_queue_reader: RD_LATENCY must be 1 or 2");
    end

    localparam logic LatLast = (RD_LATENCY == 2);

    readState_e stateQ, stateD;
    logic       latCntQ, latCntD;
    logic       loadSts, clrSts, discard;

    logic [NUM_FLAGS-1:0]      entryFlags;
    logic [DESC_NUM_WIDTH-1:0] entryDescNum;

    assign entryFlags = {fifo.rdData[INVDESC_BIT], fifo.rdData[WRERR_BIT],
                         fifo.rdData[RDERR_BIT], fifo.rdData[OPDONE_BIT]};
    assign entryDescNum = fifo.rdData[DESCNUM_LSB +: DESC_NUM_WIDTH];

    // Pops are issued only from IDLE or on a clear in HOLD, so at most one read is in flight.
    always_comb begin
        stateD    = stateQ;
        latCntD   = latCntQ;
        fifo.rdEn = 1'b0;
        loadSts   = 1'b0;
        clrSts    = 1'b0;
        discard   = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (!fifo.fifoEmpty) begin
                    fifo.rdEn = 1'b1;
                    latCntD   = 1'b0;
                    stateD    = StWait;
                end
            end
            StWait: begin
                if (latCntQ == LatLast) begin
                    latCntD = 1'b0;
                    if (|(entryFlags & intMask)) begin
                        loadSts = 1'b1;
                        stateD  = StHold;
                    end else begin
                        discard = 1'b1;
                        stateD  = StIdle;
                    end
                end else begin
                    latCntD = 1'b1;
                end
            end
            StHold: begin
                if (clrEn) begin
                    clrSts = 1'b1;
                    if (!fifo.fifoEmpty) begin
                        fifo.rdEn = 1'b1;
                        latCntD   = 1'b0;
                        stateD    = StWait;
                    end else begin
                        stateD = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stateQ  <= StIdle;
            latCntQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            latCntQ <= latCntD;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stsValid   <= 1'b0;
            stsDescNum <= '0;
            stsFlags   <= '0;
            discardCnt <= 8'd0;
        end else begin
            if (loadSts) begin
                stsValid   <= 1'b1;
                stsDescNum <= entryDescNum;
                stsFlags   <= entryFlags;
            end else if (clrSts) begin
                stsValid   <= 1'b0;
                stsDescNum <= '0;
                stsFlags   <= '0;
            end
            if (discard) begin
                discardCnt <= discardCnt + 8'd1;
            end
        end
    end

    // Sticky ECC flags: a new error in the same cycle as a clear is kept.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            eccSbSticky <= 1'b0;
            eccDbSticky <= 1'b0;
        end else begin
            eccSbSticky <= fifo.fifoSbErr | (eccSbSticky & ~eccClr);
            eccDbSticky <= fifo.fifoDbErr | (eccDbSticky & ~eccClr);
        end
    end

    assign irq = stsValid & |(stsFlags & intMask);

endmodule
